// File: rtl/uart_mmio_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_mmio_ctrl_if
// Purpose  : Memory-mapped I/O bus between the pipeline decode stage and the
//            UART controller.
// Signals  : dec_daddr  - data address (0 = UART data, 1 = UART status)
//            dec_mre    - load request
//            dec_mwe    - store request
//            wdata      - store data (bits [7:0] used)
//            rdata      - registered load result
//            io_hit     - request targets this block
//            n_stall    - pipeline advance (0 = freeze)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_mmio_ctrl_if;
  logic [24:0] dec_daddr;
  logic        dec_mre;
  logic        dec_mwe;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        io_hit;
  logic        n_stall;

  modport master (
    output dec_daddr, dec_mre, dec_mwe, wdata,
    input  rdata, io_hit, n_stall
  );

  modport slave (
    input  dec_daddr, dec_mre, dec_mwe, wdata,
    output rdata, io_hit, n_stall
  );
endinterface
`default_nettype wire

// File: rtl/uart_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_mmio_ctrl
// Purpose  : MMIO front end for a UART. Received bytes queue in an RX FIFO
//            and are popped by loads from address 0; stores to address 0
//            queue bytes in a TX FIFO drained by a four-state launcher.
//            Address 1 is a read-only status word.
// Ports    : clk          - clock, rising edge
//            rst_n        - asynchronous active-low reset
//            bus          - MMIO bus (slave modport)
//            rx_data_i    - received byte
//            rx_strobe_i  - one-cycle valid pulse for rx_data_i
//            tx_data_o    - byte to transmit (holds last sent byte)
//            tx_start_o   - one-cycle transmit launch pulse
//            tx_busy_i    - transmitter busy flag
//            rx_overrun_o - sticky RX drop flag, cleared by status read
// Params   : DEPTH        - FIFO entries, power of two in 2..64
// Revision : 1.0 - initial release
// ============================================================================
module uart_mmio_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_mmio_ctrl_if.slave        bus,
  input  logic [7:0]             rx_data_i,
  input  logic                   rx_strobe_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_start_o,
  input  logic                   tx_busy_i,
  output logic                   rx_overrun_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_ACK   = 2'd2,
    ST_DRAIN = 2'd3
  } tx_state_e;

  // State
  logic [7:0]    rx_mem_q [DEPTH];
  logic [7:0]    tx_mem_q [DEPTH];
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rx_overrun_q, rx_overrun_d;
  logic [7:0]    tx_data_q, tx_data_d;
  tx_state_e     state_q, state_d;

  // Decode
  logic w_addr0, w_addr1, w_ld0, w_ld1, w_st0;
  logic w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic w_rx_pop, w_rx_push, w_rx_drop, w_tx_push, w_tx_pop;
  logic w_unused_wdata;

  assign w_addr0 = (bus.dec_daddr == 25'd0);
  assign w_addr1 = (bus.dec_daddr == 25'd1);
  assign w_ld0   = bus.dec_mre & w_addr0;
  assign w_ld1   = bus.dec_mre & w_addr1;
  // A load takes priority over a simultaneous store.
  assign w_st0   = bus.dec_mwe & ~bus.dec_mre & w_addr0;

  // Pointers carry one extra wrap bit: equal = empty, MSB differs = full.
  assign w_rx_empty = (rx_wr_q == rx_rd_q);
  assign w_rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) &&
                      (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign w_tx_empty = (tx_wr_q == tx_rd_q);
  assign w_tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) &&
                      (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);

  assign bus.io_hit  = (bus.dec_mre | bus.dec_mwe) & (w_addr0 | w_addr1);
  assign bus.n_stall = ~((w_ld0 & w_rx_empty) | (w_st0 & w_tx_full));
  assign bus.rdata   = rdata_q;

  // Emptiness uses registered pointers, so a byte arriving this cycle is
  // never forwarded to a load in the same cycle.
  assign w_rx_pop  = w_ld0 & ~w_rx_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_rx_push = rx_strobe_i & (~w_rx_full | w_rx_pop);
  assign w_rx_drop = rx_strobe_i & w_rx_full & ~w_rx_pop;
  assign w_tx_push = w_st0 & ~w_tx_full;
  assign w_tx_pop  = (state_q == ST_SEND);

  assign w_unused_wdata = ^bus.wdata[31:8];

  assign tx_data_o    = tx_data_q;
  assign rx_overrun_o = rx_overrun_q;

  // FIFO storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_rx_push) rx_mem_q[rx_wr_q[AW-1:0]] <= rx_data_i;
    if (w_tx_push) tx_mem_q[tx_wr_q[AW-1:0]] <= bus.wdata[7:0];
  end

  // Datapath next-state
  always_comb begin
    rx_wr_d      = rx_wr_q;
    rx_rd_d      = rx_rd_q;
    tx_wr_d      = tx_wr_q;
    tx_rd_d      = tx_rd_q;
    rdata_d      = rdata_q;
    rx_overrun_d = rx_overrun_q;

    if (w_rx_push) rx_wr_d = rx_wr_q + PTR_ONE;
    if (w_rx_pop)  rx_rd_d = rx_rd_q + PTR_ONE;
    if (w_tx_push) tx_wr_d = tx_wr_q + PTR_ONE;
    if (w_tx_pop)  tx_rd_d = tx_rd_q + PTR_ONE;

    if (w_rx_pop) begin
      rdata_d = {24'd0, rx_mem_q[rx_rd_q[AW-1:0]]};
    end else if (w_ld1) begin
      rdata_d = {29'd0, rx_overrun_q, ~w_tx_full, ~w_rx_empty};
    end

    // A drop in the same cycle as a status read keeps the flag set.
    if (w_rx_drop) begin
      rx_overrun_d = 1'b1;
    end else if (w_ld1) begin
      rx_overrun_d = 1'b0;
    end
  end

  // TX launcher next-state and outputs
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_start_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!w_tx_empty && !tx_busy_i) begin
          state_d   = ST_SEND;
          // Capture the head now so tx_data_o is valid during SEND.
          tx_data_d = tx_mem_q[tx_rd_q[AW-1:0]];
        end
      end
      ST_SEND: begin
        tx_start_o = 1'b1;
        state_d    = ST_ACK;
      end
      ST_ACK: begin
        if (tx_busy_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!tx_busy_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_q      <= '0;
      rx_rd_q      <= '0;
      tx_wr_q      <= '0;
      tx_rd_q      <= '0;
      rdata_q      <= '0;
      rx_overrun_q <= 1'b0;
      tx_data_q    <= '0;
      state_q      <= ST_IDLE;
    end else begin
      rx_wr_q      <= rx_wr_d;
      rx_rd_q      <= rx_rd_d;
      tx_wr_q      <= tx_wr_d;
      tx_rd_q      <= tx_rd_d;
      rdata_q      <= rdata_d;
      rx_overrun_q <= rx_overrun_d;
      tx_data_q    <= tx_data_d;
      state_q      <= state_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_mmio_ctrl
// Purpose  : Directed self-checking bench for uart_mmio_ctrl. RX bytes and
//            TX bytes are tracked in scoreboard queues; a transmitter model
//            raises tx_busy for 10 cycles after every tx_start.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mmio_ctrl;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic       rx_overrun;

  always #5 clk = ~clk;

  uart_mmio_ctrl_if bus();

  uart_mmio_ctrl #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .rx_data_i    (rx_data),
    .rx_strobe_i  (rx_strobe),
    .tx_data_o    (tx_data),
    .tx_start_o   (tx_start),
    .tx_busy_i    (tx_busy),
    .rx_overrun_o (rx_overrun)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_start = -100;

  logic [7:0]  rx_model[$];
  logic [7:0]  tx_exp[$];
  logic [31:0] rd_exp[$];

  bit   busy_manual = 1'b1;
  logic busy_man    = 1'b0;
  int   busy_cnt    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Transmitter model and TX scoreboard consumer.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      if (tx_exp.size() == 0) begin
        chk("tx_start_unexpected", 32'(tx_start), 32'd0);
      end else begin
        chk("tx_byte", {24'd0, tx_data}, {24'd0, tx_exp.pop_front()});
      end
      chk("tx_spacing_ge12", 32'((cyc - last_start) >= 12), 32'd1);
      last_start = cyc;
      busy_cnt   = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = busy_manual ? busy_man : (busy_cnt > 0);
  end

  task automatic wait_accept(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      #1;
      if (bus.n_stall === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic rd_data(input string tag);
    bit ok;
    @(negedge clk);
    bus.dec_mre = 1'b1; bus.dec_daddr = 25'd0;
    wait_accept(20, ok);
    if (!ok) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      rd_exp.push_back(rx_model.size() > 0 ? {24'd0, rx_model.pop_front()} : 32'hFFFF_FFFF);
      #1;
      chk(tag, bus.rdata, rd_exp.pop_front());
    end
    bus.dec_mre = 1'b0;
  endtask

  task automatic rd_status(input string tag, input logic [31:0] exp);
    bit ok;
    @(negedge clk);
    bus.dec_mre = 1'b1; bus.dec_daddr = 25'd1;
    rd_exp.push_back(exp);
    wait_accept(2, ok);
    if (!ok) begin
      chk({tag, "_stalled"}, 32'd0, 32'd1);
      void'(rd_exp.pop_front());
    end else begin
      #1;
      chk(tag, bus.rdata, rd_exp.pop_front());
    end
    bus.dec_mre = 1'b0;
  endtask

  task automatic bus_write(input logic [24:0] a, input logic [7:0] d);
    bit ok;
    @(negedge clk);
    bus.dec_mwe = 1'b1; bus.dec_daddr = a; bus.wdata = {24'hABCDEF, d};
    wait_accept(40, ok);
    if (!ok) chk("write_timeout", 32'd0, 32'd1);
    else if (a == 25'd0) tx_exp.push_back(d);
    #1;
    bus.dec_mwe = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    rx_strobe = 1'b1; rx_data = b;
    if (rx_model.size() < DEPTH) rx_model.push_back(b);
    @(negedge clk);
    rx_strobe = 1'b0;
  endtask

  task automatic wait_tx_drain(input int budget, input string tag);
    int n = 0;
    while ((tx_exp.size() != 0 || tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk({tag, "_timeout"}, 32'd0, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n = 1'b0;
    bus.dec_mre = 1'b0; bus.dec_mwe = 1'b0; bus.dec_daddr = 25'd0; bus.wdata = 32'd0;
    rx_strobe = 1'b0; rx_data = 8'd0;

    // Reset values and stall decode on empty FIFOs while in reset.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_overrun", 32'(rx_overrun), 32'd0);
    chk("rst_nstall_idle", 32'(bus.n_stall), 32'd1);
    bus.dec_mre = 1'b1; #1;
    chk("rst_nstall_load_empty", 32'(bus.n_stall), 32'd0);
    chk("rst_io_hit", 32'(bus.io_hit), 32'd1);
    bus.dec_mre = 1'b0; bus.dec_mwe = 1'b1; #1;
    chk("rst_nstall_store", 32'(bus.n_stall), 32'd1);
    bus.dec_mwe = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Address decode and load priority.
    @(negedge clk);
    bus.dec_mre = 1'b1; bus.dec_daddr = 25'd2; #1;
    chk("io_hit_addr2", 32'(bus.io_hit), 32'd0);
    chk("nstall_addr2", 32'(bus.n_stall), 32'd1);
    bus.dec_daddr = 25'd1; #1;
    chk("io_hit_addr1", 32'(bus.io_hit), 32'd1);
    bus.dec_daddr = 25'd0; bus.dec_mwe = 1'b1; #1;
    chk("load_prio_stall", 32'(bus.n_stall), 32'd0);
    bus.dec_mre = 1'b0; bus.dec_mwe = 1'b0; #1;
    chk("io_hit_idle", 32'(bus.io_hit), 32'd0);

    // Load waits on empty RX; the strobed byte is not bypassed.
    @(negedge clk);
    bus.dec_mre = 1'b1; bus.dec_daddr = 25'd0;
    rx_strobe = 1'b1; rx_data = 8'h5A; rx_model.push_back(8'h5A); #1;
    chk("empty_load_stall_on_strobe", 32'(bus.n_stall), 32'd0);
    @(negedge clk);
    rx_strobe = 1'b0; #1;
    chk("empty_load_nstall_next", 32'(bus.n_stall), 32'd1);
    rd_exp.push_back({24'd0, rx_model.pop_front()});
    @(posedge clk); #1;
    chk("empty_load_rdata", bus.rdata, rd_exp.pop_front());
    bus.dec_mre = 1'b0;

    rd_status("status_idle", 32'h2);
    bus_write(25'd1, 8'h77);
    repeat (3) @(negedge clk);
    chk("rdata_hold", bus.rdata, 32'h2);

    // Two bytes through the transmitter with the busy model running.
    busy_manual = 1'b0;
    bus_write(25'd0, 8'h41);
    bus_write(25'd0, 8'h42);
    wait_tx_drain(400, "tx_pair");
    chk("tx_data_hold", {24'd0, tx_data}, 32'h42);

    // Hold busy high so the TX FIFO fills.
    @(negedge clk); busy_manual = 1'b1; busy_man = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) bus_write(25'd0, 8'hA0 + 8'(i));
    bus_write(25'd1, 8'h99);
    rd_status("status_tx_full", 32'h0);

    // RX overflow sets the sticky flag; a status read clears it.
    for (int i = 0; i < DEPTH + 1; i++) strobe(8'h10 + 8'(i));
    #1;
    chk("overrun_set", 32'(rx_overrun), 32'd1);
    rd_status("status_overrun", 32'h5);
    chk("overrun_cleared", 32'(rx_overrun), 32'd0);
    rd_status("status_after_clear", 32'h1);

    // Drop and status read in the same cycle: the drop wins.
    @(negedge clk);
    bus.dec_mre = 1'b1; bus.dec_daddr = 25'd1;
    rx_strobe = 1'b1; rx_data = 8'h1F; #1;
    chk("drop_status_nstall", 32'(bus.n_stall), 32'd1);
    @(posedge clk); #1;
    chk("drop_status_rdata", bus.rdata, 32'h1);
    chk("drop_wins_overrun", 32'(rx_overrun), 32'd1);
    rx_strobe = 1'b0; bus.dec_mre = 1'b0;
    rd_status("status_drop_win", 32'h5);
    rd_status("status_drop_clear", 32'h1);

    // Full RX: strobe and load together, then drain across the wrap.
    @(negedge clk);
    bus.dec_mre = 1'b1; bus.dec_daddr = 25'd0;
    rx_strobe = 1'b1; rx_data = 8'h19;
    rd_exp.push_back({24'd0, rx_model.pop_front()});
    rx_model.push_back(8'h19); #1;
    chk("full_pushpop_nstall", 32'(bus.n_stall), 32'd1);
    @(posedge clk); #1;
    chk("full_pushpop_rdata", bus.rdata, rd_exp.pop_front());
    chk("full_pushpop_no_overrun", 32'(rx_overrun), 32'd0);
    rx_strobe = 1'b0; bus.dec_mre = 1'b0;
    rd_status("status_still_full", 32'h1);
    for (int i = 0; i < DEPTH; i++) rd_data("rx_wrap_order");
    rd_status("status_rx_drained", 32'h0);

    // Store against a full TX FIFO stalls until the launcher pops.
    @(negedge clk);
    bus.dec_mwe = 1'b1; bus.dec_daddr = 25'd0; bus.wdata = 32'h0000_00A8;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("tx_full_stall", 32'(bus.n_stall), 32'd0);
      @(negedge clk);
    end
    busy_manual = 1'b0;
    wait_accept(20, ok);
    chk("tx_full_accept", 32'(ok), 32'd1);
    if (ok) tx_exp.push_back(8'hA8);
    #1;
    bus.dec_mwe = 1'b0;
    wait_tx_drain(600, "tx_full_burst");
    chk("tx_last_byte", {24'd0, tx_data}, 32'hA8);

    // Reset while waiting in ACK with three bytes queued.
    @(negedge clk); busy_manual = 1'b1; busy_man = 1'b0;
    for (int i = 0; i < 4; i++) bus_write(25'd0, 8'hC0 + 8'(i));
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    tx_exp.delete();
    rx_model.delete();
    #1;
    chk("midreset_tx_start", 32'(tx_start), 32'd0);
    chk("midreset_tx_data", {24'd0, tx_data}, 32'd0);
    chk("midreset_rdata", bus.rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("post_reset_no_start", 32'(tx_start), 32'd0);
    end
    rd_status("post_reset_status", 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
